out_bit_deserializer: RTL

//  Downstream consumer of middle_module's 1-bit `out` line. Frames a serial bit stream into DATA_W-bit words.

---
 rtl/out_bit_deserializer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/out_bit_deserializer.sv
// Frames a start-bit-led, LSB-first serial stream into DATA_W-bit words on a valid/ready register.
// Define DESER_PARITY_EN to expect an even-parity bit after the data bits.
module out_bit_deserializer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SAMPLE_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              enable,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              parity_err
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [DivW-1:0] DivFull = DivW'(SAMPLE_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(SAMPLE_DIV / 2 - 1);
  localparam logic [CntW-1:0] BitLast = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StHunt, StStart, StShift, StParity, StDone} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [CntW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              overflow_q, overflow_d;
  logic              parity_err_q, parity_err_d;
  logic              din_meta_q, din_s_q, din_prev_q;
  logic              rise, accept, deliver;

  assign rise   = din_s_q & ~din_prev_q;
  assign accept = m_valid_q & m_ready;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    overflow_d   = overflow_q;
    parity_err_d = 1'b0;
    deliver      = 1'b0;

    if (accept) m_valid_d = 1'b0;
    if (clr_ovf) overflow_d = 1'b0;

    if (state_q != StIdle && !enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (enable) state_d = StHunt;
        StHunt: begin
          if (rise) begin
            state_d = StStart;
            div_d   = DivHalf;
          end
        end
        StStart: begin
          if (div_q == '0) begin
            // A start bit that has dropped by mid-bit is a glitch.
            if (din_s_q) begin
              state_d = StShift;
              div_d   = DivFull;
              bit_d   = '0;
            end else begin
              state_d = StHunt;
            end
          end else begin
            div_d = div_q - 1'b1;
          end
        end
        StShift: begin
          if (div_q == '0) begin
            shift_d = DATA_W'({din_s_q, shift_q} >> 1);
            bit_d   = bit_q + 1'b1;
            div_d   = DivFull;
`ifdef DESER_PARITY_EN
            if (bit_q == BitLast) state_d = StParity;
`else
            if (bit_q == BitLast) state_d = StDone;
`endif
          end else begin
            div_d = div_q - 1'b1;
          end
        end
        StParity: begin
`ifdef DESER_PARITY_EN
          if (div_q == '0) begin
            if ((^shift_q) ^ din_s_q) begin
              parity_err_d = 1'b1;
              state_d      = StHunt;
            end else begin
              state_d = StDone;
            end
          end else begin
            div_d = div_q - 1'b1;
          end
`else
          state_d = StHunt;
`endif
        end
        StDone: begin
          deliver = 1'b1;
          state_d = StHunt;
        end
        default: state_d = StIdle;
      endcase
    end

    // Overflow set is applied after clr_ovf so a same-cycle set wins.
    if (deliver) begin
      if (!m_valid_q || accept) begin
        m_data_d  = shift_q;
        m_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      div_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      din_meta_q   <= 1'b0;
      din_s_q      <= 1'b0;
      din_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      din_meta_q   <= din;
      din_s_q      <= din_meta_q;
      din_prev_q   <= din_s_q;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;

endmodule
